// File: rtl/board_pkg.sv
// Shared types and defaults for the mole board: FSM states, tick defaults, LFSR seed.
package board_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_UP   = 2'd2,
        ST_OVER = 2'd3
    } board_state_t;

    localparam logic [27:0] SHOW_TICKS_DEF = 28'd100_000_000;
    localparam logic [27:0] GAP_TICKS_DEF  = 28'd50_000_000;
    localparam logic [27:0] SHOW_STEP_DEF  = 28'd2_000_000;
    localparam logic [27:0] SHOW_MIN_DEF   = 28'd20_000_000;
    localparam logic [7:0]  LFSR_SEED_DEF  = 8'hA5;

    // max(base - score*step, floor); evaluated wide so the subtraction never wraps
    function automatic logic [27:0] show_time(
        input logic [7:0]  score,
        input logic [27:0] base,
        input logic [27:0] step,
        input logic [27:0] floor_val
    );
        logic [36:0] red;
        red = 37'(score) * 37'(step);
        if (37'(base) >= red + 37'(floor_val))
            show_time = 28'(37'(base) - red);
        else
            show_time = floor_val;
    endfunction

endpackage

// File: rtl/board_lfsr.sv
// Free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1) plus a hole picker that never repeats
// the previously taken hole. pos is combinational; take commits it as the new previous.
module board_lfsr
    import board_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       take,
    output logic [1:0] pos
);

    logic [7:0] lfsr;
    logic [1:0] prev_pos;
    logic [1:0] cand;

    assign cand = lfsr[1:0];
    assign pos  = (cand == prev_pos) ? cand + 2'd1 : cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= SEED;
            prev_pos <= 2'd0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (take)
                prev_pos <= pos;
        end
    end

endmodule

// File: rtl/mole_board_ctrl.sv
// Whack-a-mole game controller: drives an external count-down timer via load/loadval
// and reacts to its trigger level. All outputs registered; no backpressure.
module mole_board_ctrl
    import board_pkg::*;
#(
    parameter logic [27:0] SHOW_TICKS = SHOW_TICKS_DEF,
    parameter logic [27:0] GAP_TICKS  = GAP_TICKS_DEF,
    parameter logic [27:0] SHOW_STEP  = SHOW_STEP_DEF,
    parameter logic [27:0] SHOW_MIN   = SHOW_MIN_DEF,
    parameter int unsigned MAX_MISSES = 3,
    parameter logic [7:0]  LFSR_SEED  = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  btn,
    input  logic        time_trigger,
    output logic        load,
    output logic [27:0] loadval,
    output logic [3:0]  mole,
    output logic [7:0]  score,
    output logic [3:0]  misses,
    output logic        game_over
);

    localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISSES);

    board_state_t state;
    logic [1:0]   pos;
    logic         take;
    logic         hit;
    logic         timeout;
    logic [3:0]   misses_inc;
    logic [27:0]  show_val;

    // trigger seen in a load cycle is still the previous interval's expiry
    assign timeout    = time_trigger && !load;
    assign hit        = (state == ST_UP) && ((btn & mole) != 4'd0);
    assign take       = (state == ST_GAP) && timeout;
    assign misses_inc = misses + 4'd1;
    assign show_val   = show_time(score, SHOW_TICKS, SHOW_STEP, SHOW_MIN);

    board_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .take (take),
        .pos  (pos)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            load      <= 1'b0;
            loadval   <= 28'd0;
            mole      <= 4'd0;
            score     <= 8'd0;
            misses    <= 4'd0;
            game_over <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        score     <= 8'd0;
                        misses    <= 4'd0;
                        game_over <= 1'b0;
                        mole      <= 4'd0;
                        load      <= 1'b1;
                        loadval   <= GAP_TICKS;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timeout) begin
                        mole    <= 4'b0001 << pos;
                        load    <= 1'b1;
                        loadval <= show_val;
                        state   <= ST_UP;
                    end
                end
                ST_UP: begin
                    // a hit wins over a simultaneous timeout
                    if (hit) begin
                        if (score != 8'hFF)
                            score <= score + 8'd1;
                        mole    <= 4'd0;
                        load    <= 1'b1;
                        loadval <= GAP_TICKS;
                        state   <= ST_GAP;
                    end else if (timeout) begin
                        misses <= misses_inc;
                        mole   <= 4'd0;
                        if (misses_inc == MISS_LIMIT) begin
                            game_over <= 1'b1;
                            state     <= ST_OVER;
                        end else begin
                            load    <= 1'b1;
                            loadval <= GAP_TICKS;
                            state   <= ST_GAP;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_board_ctrl.sv
// Randomized self-checking bench for mole_board_ctrl with a behavioural game model
// and a simple count-down timer model attached to load/loadval/time_trigger.
module tb_mole_board_ctrl;

    localparam int P_SHOW = 20;
    localparam int P_GAP  = 10;
    localparam int P_STEP = 2;
    localparam int P_MIN  = 6;
    localparam int P_MAXM = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  btn = 4'd0;
    logic        time_trigger;
    logic        load;
    logic [27:0] loadval;
    logic [3:0]  mole;
    logic [7:0]  score;
    logic [3:0]  misses;
    logic        game_over;

    logic        trig_force = 1'b0;
    logic [27:0] tcnt = 28'd0;

    int checks = 0;
    int errors = 0;
    int score_m = 0;
    int miss_m = 0;
    logic [3:0] prev_mole = 4'b0001;

    mole_board_ctrl #(
        .SHOW_TICKS (28'(P_SHOW)),
        .GAP_TICKS  (28'(P_GAP)),
        .SHOW_STEP  (28'(P_STEP)),
        .SHOW_MIN   (28'(P_MIN)),
        .MAX_MISSES (P_MAXM),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .btn          (btn),
        .time_trigger (time_trigger),
        .load         (load),
        .loadval      (loadval),
        .mole         (mole),
        .score        (score),
        .misses       (misses),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    // timer loaded with N raises its trigger in the Nth cycle after the load cycle
    always @(posedge clk) begin
        if (load)
            tcnt <= loadval - 28'd1;
        else if (tcnt != 28'd0)
            tcnt <= tcnt - 28'd1;
    end
    assign time_trigger = (tcnt == 28'd0) || trig_force;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_show(input int s);
        int v;
        v = P_SHOW - s * P_STEP;
        return (v < P_MIN) ? P_MIN : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_load"}, 32'(load), 0);
        check({tag, "_loadval"}, 32'(loadval), 0);
        check({tag, "_mole"}, 32'(mole), 0);
        check({tag, "_score"}, 32'(score), 0);
        check({tag, "_misses"}, 32'(misses), 0);
        check({tag, "_over"}, 32'(game_over), 0);
    endtask

    // wait for a mole; exp_gap > 0 also checks how many cycles that took
    task automatic wait_up(input int exp_gap);
        int n;
        n = 0;
        while (mole == 4'd0 && n < 200) begin
            tick();
            n++;
        end
        check("up_reached", 32'(mole != 4'd0), 1);
        if (exp_gap > 0)
            check("gap_len", n, exp_gap);
        check("up_onehot", $countones(mole), 1);
        check("up_no_repeat", 32'(mole != prev_mole), 1);
        prev_mole = mole;
        check("up_load", 32'(load), 1);
        check("up_loadval", 32'(loadval), exp_show(score_m));
    endtask

    task automatic hit();
        btn = mole;
        tick();
        btn = 4'd0;
        if (score_m < 255)
            score_m++;
        check("hit_score", 32'(score), score_m);
        check("hit_mole", 32'(mole), 0);
        check("hit_load", 32'(load), 1);
        check("hit_loadval", 32'(loadval), P_GAP);
        check("hit_misses", 32'(misses), miss_m);
    endtask

    task automatic wrong_press();
        logic [3:0] v;
        v = 4'd0;
        while (v == 4'd0)
            v = 4'($urandom_range(1, 15)) & ~mole;
        btn = v;
        tick();
        btn = 4'd0;
        check("wrong_score", 32'(score), score_m);
        check("wrong_mole", 32'(mole), 32'(prev_mole));
    endtask

    task automatic miss_wait();
        int n;
        n = 0;
        while (mole != 4'd0 && n < 200) begin
            tick();
            n++;
        end
        miss_m++;
        check("miss_len", n, exp_show(score_m) + 1);
        check("miss_count", 32'(misses), miss_m);
        check("miss_score", 32'(score), score_m);
        if (miss_m == P_MAXM) begin
            check("miss_over", 32'(game_over), 1);
            check("miss_over_load", 32'(load), 0);
        end else begin
            check("miss_over", 32'(game_over), 0);
            check("miss_load", 32'(load), 1);
            check("miss_loadval", 32'(loadval), P_GAP);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        score_m = 0;
        miss_m  = 0;
        check("start_load", 32'(load), 1);
        check("start_loadval", 32'(loadval), P_GAP);
        check("start_mole", 32'(mole), 0);
        check("start_score", 32'(score), 0);
        check("start_misses", 32'(misses), 0);
        check("start_over", 32'(game_over), 0);
    endtask

    initial begin
        int n;
        int loads;

        // reset state and idle behaviour
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        prev_mole = 4'b0001;
        loads = 0;
        repeat (5) begin
            tick();
            if (load) loads++;
        end
        check("idle_no_load", loads, 0);

        // first game: latency, wrong press, hit, reduced show time
        do_start();
        wait_up(P_GAP + 1);
        wrong_press();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_up_mole", 32'(mole), 32'(prev_mole));
        check("start_in_up_score", 32'(score), score_m);
        hit();
        wait_up(P_GAP + 1);

        // three unanswered intervals end the game
        miss_wait();
        wait_up(P_GAP + 1);
        miss_wait();
        wait_up(P_GAP + 1);
        miss_wait();
        loads = 0;
        repeat (30) begin
            tick();
            if (load) loads++;
        end
        check("over_no_load", loads, 0);
        check("over_flag", 32'(game_over), 1);
        check("over_mole", 32'(mole), 0);
        check("over_score", 32'(score), 1);
        check("over_misses", 32'(misses), P_MAXM);

        // restart, stale trigger in both load cycles
        do_start();
        trig_force = 1'b1;
        tick();
        trig_force = 1'b0;
        check("stuck_gap_mole", 32'(mole), 0);
        check("stuck_gap_load", 32'(load), 0);
        wait_up(P_GAP);
        trig_force = 1'b1;
        tick();
        trig_force = 1'b0;
        check("stuck_up_mole", 32'(mole), 32'(prev_mole));
        check("stuck_up_misses", 32'(misses), 0);
        check("stuck_up_load", 32'(load), 0);

        // hit in the very cycle the show interval expires
        n = 0;
        while (!(time_trigger && !load) && n < 100) begin
            tick();
            n++;
        end
        check("coincide_trig", 32'(time_trigger && !load), 1);
        hit();

        // climb to the show-time floor
        while (score_m < 7) begin
            wait_up(P_GAP + 1);
            if ($urandom_range(0, 1) == 1)
                wrong_press();
            repeat ($urandom_range(0, 3)) tick();
            hit();
        end
        wait_up(P_GAP + 1);
        check("floor_at_7", 32'(loadval), 6);
        hit();
        wait_up(P_GAP + 1);
        check("floor_at_8", 32'(loadval), 6);
        hit();

        // score saturation
        while (score_m < 255) begin
            wait_up(P_GAP + 1);
            repeat ($urandom_range(0, 1)) tick();
            hit();
        end
        wait_up(P_GAP + 1);
        hit();
        check("score_saturated", 32'(score), 255);

        // reset in the middle of a show interval
        wait_up(P_GAP + 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        score_m = 0;
        miss_m  = 0;
        prev_mole = 4'b0001;
        check_all_zero("midrst");
        loads = 0;
        repeat (5) begin
            tick();
            if (load || mole != 4'd0) loads++;
        end
        check("midrst_idle", loads, 0);
        do_start();
        wait_up(P_GAP + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mole_board_ctrl.md
MOLE_BOARD_CTRL -- requirements
Module: mole_board_ctrl

Interface
REQ-001 SHALL have parameter SHOW_TICKS, default 28'd100_000_000, base mole-visible time in clk cycles.
REQ-002 SHALL have parameter GAP_TICKS, default 28'd50_000_000, mole-hidden time in clk cycles.
REQ-003 SHALL have parameter SHOW_STEP, default 28'd2_000_000, show-time reduction per point scored.
REQ-004 SHALL have parameter SHOW_MIN, default 28'd20_000_000, floor on show time.
REQ-005 SHALL have parameter MAX_MISSES, default 3, misses that end the game (1..15).
REQ-006 SHALL have parameter LFSR_SEED, default 8'hA5, nonzero.
REQ-007 SHALL have ports: clk in 1, system clock; rst in 1, reset.
REQ-008 SHALL fix: one clock; reset is synchronous and active-high.
REQ-009 SHALL have ports: start in 1, game start pulse; btn in 4, one-cycle press pulses, one bit per hole.
REQ-010 SHALL have ports: time_trigger in 1, level from the external count-down timer, high while its count is 0.
REQ-011 SHALL have ports: load out 1, one-cycle timer load pulse; loadval out 28, timer load value.
REQ-012 SHALL have ports: mole out 4, one-hot visible mole or 0; score out 8; misses out 4; game_over out 1.

Function
REQ-013 SHALL implement states IDLE, GAP, UP, OVER; all outputs registered.
REQ-014 SHALL, in IDLE or OVER on start=1, clear score and misses, clear game_over, enter GAP.
REQ-015 SHALL, on every state entry into GAP or UP, drive load=1 for exactly the first cycle in that state, with loadval valid in that cycle.
REQ-016 SHALL drive loadval=GAP_TICKS on GAP entry; on UP entry loadval=max(SHOW_TICKS-score*SHOW_STEP, SHOW_MIN), compared before subtracting so no wrap.
REQ-017 SHALL ignore time_trigger in any cycle where load=1 (stale level from the previous interval).
REQ-018 SHALL, in GAP with time_trigger=1 and load=0, enter UP and set mole to one-hot of the selected position.
REQ-019 SHALL select position as lfsr[1:0]; if equal to previous position, use (lfsr[1:0]+1) mod 4.
REQ-020 SHALL advance the 8-bit LFSR (x^8+x^6+x^5+x^4+1) every cycle, including in IDLE.
REQ-021 SHALL, in UP (including the load cycle), on btn & mole != 0: score+1 saturating at 255, mole=0, enter GAP.
REQ-022 SHALL ignore btn presses not matching mole; ignore btn outside UP.
REQ-023 SHALL, in UP with time_trigger=1, load=0, no hit: misses+1, mole=0; enter OVER if new misses==MAX_MISSES, else GAP.
REQ-024 SHALL give a hit priority over timeout in the same cycle; misses unchanged.
REQ-025 SHALL, in OVER, hold game_over=1, mole=0, load=0, score/misses frozen.
REQ-026 SHALL ignore start outside IDLE and OVER.

Reset
REQ-027 SHALL, on rst=1 at a clk edge, enter IDLE; load, loadval, mole, score, misses, game_over = 0; lfsr=LFSR_SEED; previous position = 0; overrides all other inputs, including mid-game.

Structure
REQ-028 SHALL take the state enum, default tick constants and LFSR_SEED from shared package board_pkg.
REQ-029 SHALL place the LFSR and the no-repeat position select in sub-module board_lfsr.
REQ-030 SHALL NOT contain the count-down timer; it connects to an external timer at board top level.

Verification (SHOW_TICKS=20, GAP_TICKS=10, SHOW_STEP=2, SHOW_MIN=6, MAX_MISSES=3, LFSR_SEED=8'hA5; bench timer model: loads on load, trigger high when count reaches 0)
REQ-031 SHALL test: rst, start -> next cycle load=1, loadval=10, mole=0; 11 cycles later mole one-hot, load=1, loadval=20.
REQ-032 SHALL test: in UP, press btn==mole -> score=1, mole=0, load=1, loadval=10; next UP loadval=18; wrong-button press leaves score 0.
REQ-033 SHALL test: three unanswered UP intervals -> misses=3, game_over=1, mole=0, no further load; start -> score=0, misses=0, GAP loadval=10.
REQ-034 SHALL test: matching btn in same cycle as time_trigger in UP -> score+1, misses unchanged, GAP entered.
REQ-035 SHALL test: after 7 hits UP loadval=6; after 8 hits still 6; score forced 255 + hit -> stays 255.
REQ-036 SHALL test: rst asserted mid-UP -> next cycle all outputs 0, state IDLE; trigger stuck high during load cycle causes no state change; consecutive UP positions never repeat.
